// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared index/one-hot types and decode helper
package encoder_pkg;

  localparam int ENC_IW = 3;
  localparam int ENC_OW = 1 << ENC_IW;

  typedef logic [ENC_IW-1:0] idx_t;

  // Expand an encoded index into its one-hot form.
  function automatic logic [ENC_OW-1:0] onehot_f(input idx_t i);
    logic [ENC_OW-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dec_fifo.sv
// rtl/dec_fifo.sv - small power-of-two FIFO holding encoded indices
module dec_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Guard against caller mistakes: never pop empty, only push into a free slot.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is written only on an accepted push, so idle idx never lands here.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Head entry and occupancy flags.
  always_comb begin
    rdata = mem[rd_ptr];
    full  = (count == CW'(DEPTH));
    empty = (count == '0);
  end

endmodule

// File: rtl/priority_decoder.sv
// rtl/priority_decoder.sv - buffered index-to-one-hot decoder with overflow flag
module priority_decoder
  import encoder_pkg::*;
#(
  parameter int IW    = 3,
  parameter int DEPTH = 4,
  localparam int OW   = 2 ** IW,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] idx,
  input  logic          vin,
  output logic [OW-1:0] out,
  output logic          vout,
  input  logic          rdy,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic          clr_ovf
);

  logic [IW-1:0] head_idx;
  logic [OW-1:0] head_onehot;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;

  dec_fifo #(
    .DEPTH (DEPTH),
    .W     (IW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (idx),
    .rdata (head_idx),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // A pop on a full FIFO frees the slot the same edge, so the push still fits.
  always_comb begin
    vout = !empty;
    pop  = vout && rdy;
    push = vin && (!full || pop);
    drop = vin && full && !pop;
  end

  // Use the shared helper at the native width, plain shift otherwise.
  generate
    if (IW == ENC_IW) begin : g_pkg_decode
      always_comb head_onehot = OW'(onehot_f(idx_t'(head_idx)));
    end else begin : g_shift_decode
      always_comb head_onehot = OW'(1) << head_idx;
    end
  endgenerate

  // Output is forced to zero whenever nothing is queued.
  always_comb begin
    out = vout ? head_onehot : '0;
  end

  // Sticky drop flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: doc/priority_decoder.md
Name: priority_decoder

Overview:
- Decoder counterpart to the priority encoder: it converts a 3-bit encoded index plus valid back into an 8-bit one-hot vector.
- Upstream has no backpressure (vin/data only), so the block buffers decoded requests in a small FIFO and drains them under a downstream ready.
- Sits on the return path, between an encoder-style producer and a one-hot consumer such as a grant or arbiter bank.
- Drops on overflow are flagged, not silent.

Parameters:
- IW, 3, index width; the one-hot output width is OW = 2**IW (8).
- DEPTH, 4, number of FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- idx  input  IW  encoded index from the producer.
- vin  input  1  idx valid; sampled on every clk edge, no handshake back.
- out  output  OW  one-hot decode of the FIFO head; all zeros when vout=0.
- vout  output  1  out valid (FIFO not empty).
- rdy  input  1  downstream ready; a pop occurs on an edge where vout && rdy.
- full  output  1  FIFO holds DEPTH entries.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a vin was dropped.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst_n low, asynchronous): pointers and count go to 0; vout=0, out=0, full=0, overflow=0. Stored entries are don't-care.
- Storage: the FIFO stores idx (IW bits), not one-hot.
- out = vout ? (1 << head_idx) : 0. It is driven from flops through the decode only; there is no combinational path from idx or vin to out.
- Latency: idx accepted at edge N into an empty FIFO appears with vout=1 after edge N. There is no same-cycle bypass.
- push = vin && (!full || pop). pop = vout && rdy.
- Simultaneous push and pop:
  - Count is unchanged and both pointers advance.
  - When full, the push is accepted because the pop frees a slot in the same edge.
  - When empty, pop=0 because vout=0, so only the push occurs.
- Overflow: vin && full && !pop means idx is discarded and overflow is set on that edge.
  - clr_ovf clears overflow.
  - If clr_ovf and a new drop occur on the same edge, set wins and overflow stays 1.
- Pointers: wrap modulo DEPTH. Count ranges from 0 to DEPTH; full = (count == DEPTH).
- rdy without vout has no effect. vout never drops while rdy=0 (output holds stable until popped).
- Reset mid-operation discards all entries immediately; the first vin after rst_n deasserts is stored normally.
- idx is don't-care when vin=0. X on idx with vin=0 must not propagate to out.

Decomposition:
- Shared package (encoder_pkg):
  - ENC_IW = 3 and ENC_OW = 8 constants.
  - An idx_t typedef (logic [ENC_IW-1:0]).
  - A function onehot_f(idx_t) returning logic [ENC_OW-1:0].
- One sub-module: dec_fifo (parameterised DEPTH/W storage with push/pop/count/full).
- The decode and the overflow flag stay in the top.

Test Plan:
- Reset then idle: rst_n=0 for 2 clocks, then release with vin=0 → vout=0, out=8'h00, count=0, overflow=0.
- Single decode: idx=3'd5, vin=1 for one edge, rdy=1 → next cycle vout=1, out=8'b0010_0000; one edge later vout=0, count=0.
- Fill and stall: rdy=0, push idx 0,7,2,4 → full=1, count=4. A 5th vin with idx=1 → overflow=1, count stays 4. Then rdy=1 drains out 8'h01, 8'h80, 8'h04, 8'h10 in order.
- Full with simultaneous push/pop: FIFO full, rdy=1 and vin=1 with idx=6 on the same edge → count stays 4, overflow stays 0, and 8'h40 emerges last.
- Sticky clear race: overflow=1, pulse clr_ovf → overflow=0. Assert clr_ovf on the same edge as a new drop → overflow=1.
- Async reset mid-drain: count=3, pull rst_n low between edges → vout=0, out=0, count=0 immediately, without waiting for clk.
